mem_access_stage: RTL and testbench

- MEM stage of the V850 5-stage pipeline, directly downstream of the executer (EX→MEM boundary) and upstream of register writeback.
- Takes the EX result (effective address or ALU value), the secondary result, both destinations and the PC.
- Performs load/store through a req/gnt/rvalid data-memory port and aligns and extends load data.
- Stalls EX while an access is outstanding, then presents one registered writeback record per instruction.

---
 rtl/v850_pkg.sv | 41 ++++
 rtl/mem_access_stage_load_align.sv | 25 ++
 rtl/mem_access_stage.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v850_pkg.sv
// Shared types for the V850 MEM stage: memory op/size encodings, FSM states and PC width.
package v850_pkg;

    localparam int PC_W = 25;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } mem_op_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_R
    } mem_state_t;

    // Reserved size code 11 behaves as a word access.
    function automatic mem_size_t decode_size(logic [1:0] s);
        case (s)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(mem_size_t sz, logic [1:0] a);
        case (sz)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~a[0];
            default: return a == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data alignment: picks the addressed lane of a little-endian word and extends it.
module load_align
    import v850_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  mem_size_t   size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = rdata;
        unique case (size)
            SZ_BYTE: data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// V850 MEM stage: issues load/store on a req/gnt/rvalid port, stalls EX while busy,
// and emits one registered writeback record per accepted instruction.
module mem_access_stage
    import v850_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic [1:0]      mem_op_i,
    input  logic [1:0]      mem_size_i,
    input  logic            sign_ext_i,
    input  logic [31:0]     result_i,
    input  logic [31:0]     result2_i,
    input  logic [4:0]      destination_i,
    input  logic [4:0]      destination2_i,
    input  logic [PC_W-1:0] PC_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [31:0]     dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [31:0]     dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [31:0]     dmem_rdata_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_destination_o,
    output logic [31:0]     wb_data_o,
    output logic [4:0]      wb_destination2_o,
    output logic [31:0]     wb_data2_o,
    output logic [PC_W-1:0] wb_PC_o,
    output logic            misalign_o,
    output logic            bus_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t state, next_state;
    logic [CNT_W-1:0] cnt;

    logic            lat_load, lat_sext;
    mem_size_t       lat_size;
    logic [1:0]      lat_off;
    logic [4:0]      lat_dest, lat_dest2;
    logic [31:0]     lat_data2;
    logic [PC_W-1:0] lat_pc;

    logic        accept, is_load, is_store, is_mem, misal, start;
    logic        expired, complete, abort;
    mem_size_t   size_in;
    logic [3:0]  req_be;
    logic [31:0] req_wdata, load_data;

    assign ex_ready_o = (state == IDLE);
    assign accept     = ex_valid_i && ex_ready_o;
    assign is_load    = (mem_op_i == MEM_LOAD);
    assign is_store   = (mem_op_i == MEM_STORE);
    assign is_mem     = is_load || is_store;
    assign size_in    = decode_size(mem_size_i);
    assign misal      = is_mem && !is_aligned(size_in, result_i[1:0]);
    assign start      = accept && is_mem && !misal;
    assign expired    = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        req_be    = 4'b1111;
        req_wdata = result2_i;
        unique case (size_in)
            SZ_BYTE: begin
                req_be    = 4'b0001 << result_i[1:0];
                req_wdata = {4{result2_i[7:0]}};
            end
            SZ_HALF: begin
                req_be    = result_i[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{result2_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // gnt/rvalid win over a timeout landing in the same cycle.
    always_comb begin
        next_state = state;
        complete   = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: if (start) next_state = WAIT_GNT;
            WAIT_GNT: begin
                if (dmem_gnt_i) begin
                    if (lat_load) next_state = WAIT_R;
                    else begin
                        next_state = IDLE;
                        complete   = 1'b1;
                    end
                end else if (expired) begin
                    next_state = IDLE;
                    abort      = 1'b1;
                end
            end
            WAIT_R: begin
                if (dmem_rvalid_i) begin
                    next_state = IDLE;
                    complete   = 1'b1;
                end else if (expired) begin
                    next_state = IDLE;
                    abort      = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    load_align u_load_align (
        .rdata    (dmem_rdata_i),
        .offset   (lat_off),
        .size     (lat_size),
        .sign_ext (lat_sext),
        .data     (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt               <= '0;
            lat_load          <= 1'b0;
            lat_sext          <= 1'b0;
            lat_size          <= SZ_BYTE;
            lat_off           <= 2'b00;
            lat_dest          <= '0;
            lat_dest2         <= '0;
            lat_data2         <= '0;
            lat_pc            <= '0;
            dmem_req_o        <= 1'b0;
            dmem_we_o         <= 1'b0;
            dmem_addr_o       <= '0;
            dmem_be_o         <= '0;
            dmem_wdata_o      <= '0;
            wb_valid_o        <= 1'b0;
            wb_destination_o  <= '0;
            wb_data_o         <= '0;
            wb_destination2_o <= '0;
            wb_data2_o        <= '0;
            wb_PC_o           <= '0;
            misalign_o        <= 1'b0;
            bus_err_o         <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;

            if (next_state != state)  cnt <= '0;
            else if (state != IDLE)   cnt <= cnt + 1'b1;

            if (accept) begin
                lat_load  <= is_load;
                lat_sext  <= sign_ext_i;
                lat_size  <= size_in;
                lat_off   <= result_i[1:0];
                lat_dest  <= destination_i;
                lat_dest2 <= destination2_i;
                lat_data2 <= result2_i;
                lat_pc    <= PC_i;
                if (start) begin
                    dmem_req_o   <= 1'b1;
                    dmem_we_o    <= is_store;
                    dmem_addr_o  <= {result_i[31:2], 2'b00};
                    dmem_be_o    <= req_be;
                    dmem_wdata_o <= req_wdata;
                end else begin
                    // Non-memory ops and misaligned accesses retire next cycle without a bus cycle.
                    wb_valid_o        <= 1'b1;
                    misalign_o        <= misal;
                    wb_destination_o  <= destination_i;
                    wb_data_o         <= misal ? 32'h0 : result_i;
                    wb_destination2_o <= destination2_i;
                    wb_data2_o        <= result2_i;
                    wb_PC_o           <= PC_i;
                end
            end

            if (state == WAIT_GNT && dmem_gnt_i) dmem_req_o <= 1'b0;

            if (complete || abort) begin
                dmem_req_o        <= 1'b0;
                wb_valid_o        <= 1'b1;
                bus_err_o         <= abort;
                wb_destination_o  <= lat_dest;
                wb_data_o         <= (complete && lat_load) ? load_data : 32'h0;
                wb_destination2_o <= lat_dest2;
                wb_data2_o        <= lat_data2;
                wb_PC_o           <= lat_pc;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table, directed multi-cycle sequences, and a
// randomized run against a byte-addressed memory model with a randomly stalling slave.
module tb_mem_access_stage;
    import v850_pkg::*;

    logic            clk, rst;
    logic            ex_valid, ex_ready;
    logic [1:0]      mem_op, mem_size;
    logic            sign_ext;
    logic [31:0]     result, result2;
    logic [4:0]      dest, dest2;
    logic [PC_W-1:0] pc;
    logic            dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0]     dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]      dmem_be;
    logic            wb_valid, misalign, bus_err;
    logic [4:0]      wb_dest, wb_dest2;
    logic [31:0]     wb_data, wb_data2;
    logic [PC_W-1:0] wb_pc;

    logic        slave_auto;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;
    logic        s_gnt, s_rvalid;
    logic [31:0] s_rdata;

    int n_pass, n_total;

    logic [7:0]  model_mem [64];
    logic [31:0] slave_mem [16];

    assign dmem_gnt    = slave_auto ? s_gnt    : m_gnt;
    assign dmem_rvalid = slave_auto ? s_rvalid : m_rvalid;
    assign dmem_rdata  = slave_auto ? s_rdata  : m_rdata;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid_i        (ex_valid),
        .ex_ready_o        (ex_ready),
        .mem_op_i          (mem_op),
        .mem_size_i        (mem_size),
        .sign_ext_i        (sign_ext),
        .result_i          (result),
        .result2_i         (result2),
        .destination_i     (dest),
        .destination2_i    (dest2),
        .PC_i              (pc),
        .dmem_req_o        (dmem_req),
        .dmem_we_o         (dmem_we),
        .dmem_addr_o       (dmem_addr),
        .dmem_be_o         (dmem_be),
        .dmem_wdata_o      (dmem_wdata),
        .dmem_gnt_i        (dmem_gnt),
        .dmem_rvalid_i     (dmem_rvalid),
        .dmem_rdata_i      (dmem_rdata),
        .wb_valid_o        (wb_valid),
        .wb_destination_o  (wb_dest),
        .wb_data_o         (wb_data),
        .wb_destination2_o (wb_dest2),
        .wb_data2_o        (wb_data2),
        .wb_PC_o           (wb_pc),
        .misalign_o        (misalign),
        .bus_err_o         (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic drive(input logic [1:0] op, input logic [1:0] sz, input logic se,
                         input logic [31:0] r, input logic [31:0] r2, input logic [4:0] d,
                         input logic [PC_W-1:0] p);
        mem_op = op; mem_size = sz; sign_ext = se;
        result = r; result2 = r2; dest = d; dest2 = d + 5'd1; pc = p;
    endtask

    // Slave: grants after 0..2 idle cycles, returns read data 1..2 cycles after the grant.
    int          gdelay, rwait, s_idx;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_wd;
    always @(posedge clk) begin
        #1;
        if (!slave_auto) begin
            for (int w = 0; w < 16; w++)
                slave_mem[w] = {model_mem[4*w+3], model_mem[4*w+2], model_mem[4*w+1], model_mem[4*w]};
            s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0;
            gdelay = 0; rwait = 0;
        end else begin
            if (s_gnt) begin
                if (s_we) begin
                    for (int b = 0; b < 4; b++)
                        if (s_be[b]) slave_mem[s_idx][8*b +: 8] = s_wd[8*b +: 8];
                end else rwait = $urandom_range(1, 2);
            end
            s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = $urandom;
            if (rwait > 0) begin
                rwait--;
                if (rwait == 0) begin
                    s_rvalid = 1'b1;
                    s_rdata  = slave_mem[s_idx];
                end
            end else if (dmem_req) begin
                if (gdelay == 0) begin
                    s_gnt  = 1'b1;
                    s_idx  = int'((dmem_addr - 32'h100) >> 2) & 15;
                    s_we   = dmem_we;
                    s_be   = dmem_be;
                    s_wd   = dmem_wdata;
                    gdelay = $urandom_range(0, 2);
                end else gdelay--;
            end
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic [31:0] res;
        logic [31:0] res2;
        logic [4:0]  dst;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int req_cycles;
        n_pass = 0; n_total = 0;
        rst = 1'b1; slave_auto = 1'b0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
        ex_valid = 1'b0;
        drive(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, '0);
        for (int i = 0; i < 64; i++) model_mem[i] = 8'($urandom);

        vecs[0] = '{2'b00, 2'b00, 32'h12345678, 32'h11111111, 5'd7,  32'h12345678, 1'b0};
        vecs[1] = '{2'b00, 2'b00, 32'h12345678, 32'h22222222, 5'd7,  32'h12345678, 1'b0};
        vecs[2] = '{2'b00, 2'b10, 32'h12345678, 32'h33333333, 5'd7,  32'h12345678, 1'b0};
        vecs[3] = '{2'b11, 2'b01, 32'hCAFEF00D, 32'h44444444, 5'd9,  32'hCAFEF00D, 1'b0};
        vecs[4] = '{2'b01, 2'b10, 32'h00003002, 32'h55555555, 5'd10, 32'h00000000, 1'b1};
        vecs[5] = '{2'b10, 2'b01, 32'h00002001, 32'h66666666, 5'd11, 32'h00000000, 1'b1};
        vecs[6] = '{2'b01, 2'b11, 32'h00000041, 32'h77777777, 5'd12, 32'h00000000, 1'b1};

        repeat (3) step();
        chk("reset wb_valid", 32'(wb_valid), 32'd0);
        chk("reset req", 32'(dmem_req), 32'd0);
        chk("reset ex_ready", 32'(ex_ready), 32'd1);
        chk("reset wb_data", wb_data, 32'h0);
        chk("reset addr", dmem_addr, 32'h0);
        chk("reset flags", {30'd0, misalign, bus_err}, 32'd0);
        rst = 1'b0;
        step();
        chk("post-reset wb_valid", 32'(wb_valid), 32'd0);

        // Back-to-back single-cycle ops: pass-through and misaligned accesses.
        ex_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].op, vecs[i].size, 1'b1, vecs[i].res, vecs[i].res2, vecs[i].dst, PC_W'(i + 100));
            step();
            chk($sformatf("vec%0d wb_valid", i), 32'(wb_valid), 32'd1);
            chk($sformatf("vec%0d wb_data", i), wb_data, vecs[i].exp_data);
            chk($sformatf("vec%0d wb_data2", i), wb_data2, vecs[i].res2);
            chk($sformatf("vec%0d dests", i), {22'd0, wb_dest, wb_dest2}, {22'd0, vecs[i].dst, vecs[i].dst + 5'd1});
            chk($sformatf("vec%0d pc", i), 32'(wb_pc), 32'(i + 100));
            chk($sformatf("vec%0d misalign", i), 32'(misalign), 32'(vecs[i].exp_mis));
            chk($sformatf("vec%0d no req", i), 32'(dmem_req), 32'd0);
            chk($sformatf("vec%0d ex_ready", i), 32'(ex_ready), 32'd1);
        end
        ex_valid = 1'b0;
        step();
        chk("vec tail wb_valid", 32'(wb_valid), 32'd0);
        chk("vec tail misalign", 32'(misalign), 32'd0);

        // Load byte, sign-extended, with a stray rvalid in the grant cycle.
        drive(2'b01, 2'b00, 1'b1, 32'h1003, 32'h0, 5'd4, PC_W'(32'h200));
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        chk("lb req", 32'(dmem_req), 32'd1);
        chk("lb addr", dmem_addr, 32'h1000);
        chk("lb be", 32'(dmem_be), 32'b1000);
        chk("lb we", 32'(dmem_we), 32'd0);
        chk("lb ex_ready wait_gnt", 32'(ex_ready), 32'd0);
        step();
        chk("lb req held", 32'(dmem_req), 32'd1);
        m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
        step();
        m_gnt = 1'b0;
        chk("lb req dropped", 32'(dmem_req), 32'd0);
        chk("lb gnt-cycle rvalid ignored", 32'(wb_valid), 32'd0);
        chk("lb ex_ready wait_r", 32'(ex_ready), 32'd0);
        m_rvalid = 1'b1; m_rdata = 32'h80FFFF00;
        step();
        m_rvalid = 1'b0;
        chk("lb wb_valid", 32'(wb_valid), 32'd1);
        chk("lb wb_data", wb_data, 32'hFFFFFF80);
        chk("lb ex_ready", 32'(ex_ready), 32'd1);
        step();
        chk("lb pulse", 32'(wb_valid), 32'd0);

        // Store halfword at the upper half of the word.
        drive(2'b10, 2'b01, 1'b0, 32'h2002, 32'hAAAABEEF, 5'd5, PC_W'(32'h204));
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        chk("sh be", 32'(dmem_be), 32'b1100);
        chk("sh wdata", dmem_wdata, 32'hBEEFBEEF);
        chk("sh we", 32'(dmem_we), 32'd1);
        chk("sh addr", dmem_addr, 32'h2000);
        m_gnt = 1'b1;
        step();
        m_gnt = 1'b0;
        chk("sh wb_valid", 32'(wb_valid), 32'd1);
        chk("sh wb_data", wb_data, 32'h0);
        chk("sh req dropped", 32'(dmem_req), 32'd0);
        step();
        chk("sh pulse", 32'(wb_valid), 32'd0);

        // Grant never arrives: abort after four wait cycles.
        drive(2'b01, 2'b10, 1'b0, 32'h4000, 32'h0, 5'd6, PC_W'(32'h208));
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        req_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            if (dmem_req) req_cycles++;
            step();
        end
        chk("to req cycles", 32'(req_cycles), 32'd4);
        chk("to req dropped", 32'(dmem_req), 32'd0);
        chk("to bus_err", 32'(bus_err), 32'd1);
        chk("to wb_valid", 32'(wb_valid), 32'd1);
        chk("to wb_data", wb_data, 32'h0);
        chk("to ex_ready", 32'(ex_ready), 32'd1);
        drive(2'b00, 2'b00, 1'b0, 32'h55AA55AA, 32'h0, 5'd3, PC_W'(32'h20C));
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        chk("to next wb_valid", 32'(wb_valid), 32'd1);
        chk("to next wb_data", wb_data, 32'h55AA55AA);
        chk("to next bus_err", 32'(bus_err), 32'd0);
        step();

        // Reset while waiting for read data, then a stray rvalid.
        drive(2'b01, 2'b10, 1'b0, 32'h1000, 32'h0, 5'd8, PC_W'(32'h210));
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        m_gnt = 1'b1;
        step();
        m_gnt = 1'b0;
        step();
        rst = 1'b1;
        #2;
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst ex_ready", 32'(ex_ready), 32'd1);
        chk("rst wb_data", wb_data, 32'h0);
        rst = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h12345678;
        step();
        m_rvalid = 1'b0;
        chk("stray rvalid wb_valid", 32'(wb_valid), 32'd0);
        chk("stray rvalid ex_ready", 32'(ex_ready), 32'd1);
        chk("stray rvalid wb_data", wb_data, 32'h0);
        chk("stray rvalid req", 32'(dmem_req), 32'd0);
        step();
        chk("stray rvalid later", 32'(wb_valid), 32'd0);

        // Randomized run against the byte-level memory model.
        slave_auto = 1'b1;
        for (int n = 0; n < 150; n++) begin
            logic [1:0]  op, sz;
            logic        se, is_mem, mis;
            int          off, nb, k;
            logic [31:0] r, r2, expd;
            logic [63:0] v, mask;
            logic [4:0]  d;
            logic [PC_W-1:0] p;
            op = 2'($urandom_range(0, 3)); sz = 2'($urandom_range(0, 3));
            se = 1'($urandom_range(0, 1)); off = $urandom_range(0, 63);
            is_mem = (op == 2'b01) || (op == 2'b10);
            r  = is_mem ? 32'h100 + 32'(off) : $urandom;
            r2 = $urandom; d = 5'($urandom); p = PC_W'($urandom);
            nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            mis = is_mem && (off % nb != 0);
            if (!is_mem) expd = r;
            else if (mis) expd = 32'h0;
            else if (op == 2'b10) begin
                expd = 32'h0;
                for (int i = 0; i < nb; i++) model_mem[off + i] = r2[8*i +: 8];
            end else begin
                v = 64'h0;
                for (int i = 0; i < nb; i++) v = v | (64'(model_mem[off + i]) << (8 * i));
                mask = (64'd1 << (8 * nb)) - 64'd1;
                if (se && v[8*nb-1]) v = v | ~mask;
                expd = v[31:0];
            end
            drive(op, sz, se, r, r2, d, p);
            ex_valid = 1'b1;
            step();
            ex_valid = 1'b0;
            k = 0;
            while (!wb_valid && k < 20) begin
                step();
                k++;
            end
            chk($sformatf("rnd%0d completes", n), 32'(wb_valid), 32'd1);
            chk($sformatf("rnd%0d wb_data", n), wb_data, expd);
            chk($sformatf("rnd%0d wb_data2", n), wb_data2, r2);
            chk($sformatf("rnd%0d dests", n), {22'd0, wb_dest, wb_dest2}, {22'd0, d, d + 5'd1});
            chk($sformatf("rnd%0d pc", n), 32'(wb_pc), 32'(p));
            chk($sformatf("rnd%0d flags", n), {30'd0, misalign, bus_err}, {30'd0, mis, 1'b0});
            step();
            chk($sformatf("rnd%0d pulse", n), 32'(wb_valid), 32'd0);
        end
        for (int w = 0; w < 16; w++)
            chk($sformatf("mem word %0d", w), slave_mem[w],
                {model_mem[4*w+3], model_mem[4*w+2], model_mem[4*w+1], model_mem[4*w]});
        slave_auto = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
